// File: rtl/i2c_aux_req_engine.sv
// ---------------------------------------------------------------------------
// i2c_aux_req_engine
//
// Splits one I2C-over-AUX transaction from the DP source de-mux into AUX
// request headers of at most CHUNK data bytes each. Each header is streamed
// one byte per cycle: B0 = {0, MOT, cmd, addr[19:16]}, B1 = addr[15:8],
// B2 = addr[7:0], B3 = chunk-1. An address-only transaction (N=0) sends
// B0..B2 only. Each chunk is retried on DEFER or timeout up to MAX_RETRY
// times. A NACK, or running out of retries, ends the transaction as failed.
// Write payload bytes are inserted downstream and are not emitted here.
//
// Parameters:
//   CHUNK      max data bytes per AUX request (1..16)
//   MAX_RETRY  retries allowed per chunk after the first attempt
//   LEN_W      width of the total-length input
//   RW         retry counter width, derived from MAX_RETRY (do not override)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   de_mux_i2c_tr_vld    transaction valid (sampled in IDLE only)
//   de_mux_i2c_cmd       00 write, 01 read, 10 write-status-update
//   de_mux_i2c_address   20-bit AUX address
//   de_mux_i2c_len       total byte count N (0 = address-only)
//   reply_ack            00 ACK, 01 NACK, 10 DEFER, 11 treated as NACK
//   reply_ack_vld        reply_ack valid this cycle
//   timer_timeout        reply timeout pulse
//   i2c_splitted_msg     header byte
//   i2c_msg_vld          header byte valid
//   i2c_fsm_complete     one-cycle success pulse
//   i2c_fsm_failed       one-cycle failure pulse
//   i2c_busy             engine not in IDLE
//   i2c_retry_cnt        retries used on the current chunk
// ---------------------------------------------------------------------------
module i2c_aux_req_engine #(
  parameter int CHUNK     = 16,
  parameter int MAX_RETRY = 7,
  parameter int LEN_W     = 8,
  parameter int RW        = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_mux_i2c_tr_vld,
  input  logic [1:0]       de_mux_i2c_cmd,
  input  logic [19:0]      de_mux_i2c_address,
  input  logic [LEN_W-1:0] de_mux_i2c_len,
  input  logic [1:0]       reply_ack,
  input  logic             reply_ack_vld,
  input  logic             timer_timeout,
  output logic [7:0]       i2c_splitted_msg,
  output logic             i2c_msg_vld,
  output logic             i2c_fsm_complete,
  output logic             i2c_fsm_failed,
  output logic             i2c_busy,
  output logic [RW-1:0]    i2c_retry_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HDR    = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam logic [1:0] REPLY_ACK   = 2'b00;
  localparam logic [1:0] REPLY_DEFER = 2'b10;

  // Data bytes carried by the chunk that starts with `rem` bytes outstanding.
  function automatic logic [LEN_W-1:0] chunk_of(input logic [LEN_W-1:0] rem);
    if (int'(rem) > CHUNK) return LEN_W'(CHUNK);
    else                   return rem;
  endfunction

  // More chunks follow this one.
  function automatic logic mot_of(input logic [LEN_W-1:0] rem);
    return int'(rem) > CHUNK;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [1:0]       idx,
                                          input logic [1:0]       cmd,
                                          input logic [19:0]      addr,
                                          input logic [LEN_W-1:0] rem);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {1'b0, mot_of(rem), cmd, addr[19:16]};
      2'd1:    b = addr[15:8];
      2'd2:    b = addr[7:0];
      default: b = 8'(chunk_of(rem) - LEN_W'(1));
    endcase
    return b;
  endfunction

  // Control / datapath state
  state_e           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [19:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;      // bytes not yet acknowledged
  logic [1:0]       idx_q, idx_d;      // header byte currently on the output
  logic [RW-1:0]    retry_q, retry_d;
  logic             done_ok, done_fail;

  // Registered outputs
  logic [7:0]       msg_q, msg_d;
  logic             vld_q, vld_d;
  logic             complete_q, complete_d;
  logic             failed_q, failed_d;
  logic             busy_q, busy_d;

  logic [1:0]       last_idx;
  logic             is_ack, is_retry, is_nack;

  // An address-only transaction keeps rem at zero and sends only B0..B2.
  assign last_idx = (rem_q == '0) ? 2'd2 : 2'd3;

  // A reply in the same cycle as a timeout wins; a lone timeout acts like DEFER.
  assign is_ack   = reply_ack_vld && (reply_ack == REPLY_ACK);
  assign is_retry = reply_ack_vld ? (reply_ack == REPLY_DEFER) : timer_timeout;
  assign is_nack  = reply_ack_vld && (reply_ack != REPLY_ACK) && (reply_ack != REPLY_DEFER);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    done_ok   = 1'b0;
    done_fail = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (de_mux_i2c_tr_vld) begin
          state_d = S_HDR;
          cmd_d   = de_mux_i2c_cmd;
          addr_d  = de_mux_i2c_address;
          rem_d   = de_mux_i2c_len;
          idx_d   = 2'd0;
          retry_d = '0;
        end
      end

      S_HDR: begin
        if (idx_q == last_idx) state_d = S_WAIT;
        else                   idx_d   = idx_q + 2'd1;
      end

      S_WAIT: begin
        if (is_ack) begin
          rem_d   = rem_q - chunk_of(rem_q);
          retry_d = '0;
          if (rem_d == '0) begin
            state_d = S_FINISH;
            done_ok = 1'b1;
          end else begin
            state_d = S_HDR;
            idx_d   = 2'd0;
          end
        end else if (is_retry) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = S_HDR;
            idx_d   = 2'd0;
          end else begin
            state_d   = S_FINISH;
            done_fail = 1'b1;
          end
        end else if (is_nack) begin
          state_d   = S_FINISH;
          done_fail = 1'b1;
        end
      end

      S_FINISH: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: outputs are computed from the next state so that they are
  // registered yet appear in the cycle right after the deciding edge.
  // -------------------------------------------------------------------------
  always_comb begin
    vld_d      = (state_d == S_HDR);
    msg_d      = vld_d ? hdr_byte(idx_d, cmd_d, addr_d, rem_d) : 8'h00;
    complete_d = done_ok;
    failed_d   = done_fail;
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q      <= 8'h00;
      vld_q      <= 1'b0;
      complete_q <= 1'b0;
      failed_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      msg_q      <= msg_d;
      vld_q      <= vld_d;
      complete_q <= complete_d;
      failed_q   <= failed_d;
      busy_q     <= busy_d;
    end
  end

  assign i2c_splitted_msg = msg_q;
  assign i2c_msg_vld      = vld_q;
  assign i2c_fsm_complete = complete_q;
  assign i2c_fsm_failed   = failed_q;
  assign i2c_busy         = busy_q;
  assign i2c_retry_cnt    = retry_q;

endmodule
